// File: rtl/cl_capture_ctrl.sv
// cl_capture_ctrl: capture sequencer between the Camera Link receive AXIS
// stream and a downstream video DMA. Arms on cmd_start, aligns to the next
// start-of-frame (tuser), forwards whole frames only and stops after
// frame_count_cfg frames (0 = continuous) or at the frame boundary after
// cmd_stop. The non-stallable receiver feeds a FIFO of FIFO_DEPTH beats; the
// beat presented on M_AXIS is the FIFO head, held in registers.
//
// Optional build macro: CL_LINE_CHECK_EN enables per-frame line-length
// checking (line_len_err); without it line_len_err is tied to 0.
//
// Ports:
//   M_AXIS_aclk, M_AXIS_aresetn   clock, async active-low reset
//   S_AXIS_*                      receiver stream in (tready tied to 1)
//   fval                          Camera Link frame-valid, beat aligned
//   M_AXIS_*                      registered stream out to the DMA
//   cmd_start, cmd_stop           one-cycle software commands
//   frame_count_cfg               frames to capture, sampled at cmd_start
//   busy, frames_done             capture status
//   overflow, line_len_err        sticky error flags, cleared at cmd_start
module cl_capture_ctrl #(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH         = 16
) (
    input  logic                          M_AXIS_aclk,
    input  logic                          M_AXIS_aresetn,
    input  logic                          S_AXIS_tvalid,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                          S_AXIS_tlast,
    input  logic                          S_AXIS_tuser,
    output logic                          S_AXIS_tready,
    input  logic                          fval,
    input  logic                          M_AXIS_tready,
    output logic                          M_AXIS_tvalid,
    output logic [C_AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                          M_AXIS_tlast,
    output logic                          M_AXIS_tuser,
    input  logic                          cmd_start,
    input  logic                          cmd_stop,
    input  logic [15:0]                   frame_count_cfg,
    output logic                          busy,
    output logic [15:0]                   frames_done,
    output logic                          overflow,
    output logic                          line_len_err
);

    localparam int unsigned DW = C_AXIS_TDATA_WIDTH;
    localparam int unsigned EW = DW + 2;
    localparam int unsigned AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DRAIN} state_t;

    state_t         state, state_nxt;
    logic           fval_q;
    logic [15:0]    cfg_q;
    logic           stop_pending, stop_pending_nxt;
    logic [15:0]    frames_nxt;
    logic           start_c;
    logic           push_req;
    logic           fval_fall;

    logic [EW-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr, rd_nxt;
    logic [CW-1:0]  count, count_nxt;
    logic           full, push, pop, drop;
    logic [EW-1:0]  wdata, head_nxt;

    assign S_AXIS_tready = 1'b1;
    assign fval_fall     = fval_q & ~fval;

    // Next-state and frame accounting
    always_comb begin
        state_nxt        = state;
        stop_pending_nxt = stop_pending;
        frames_nxt       = frames_done;
        start_c          = 1'b0;
        push_req         = 1'b0;
        case (state)
            S_IDLE: begin
                // stop wins over a simultaneous start
                if (cmd_start && !cmd_stop) begin
                    start_c          = 1'b1;
                    stop_pending_nxt = 1'b0;
                    frames_nxt       = 16'd0;
                    state_nxt        = S_ARMED;
                end
            end
            S_ARMED: begin
                if (cmd_stop) begin
                    state_nxt = S_DRAIN;
                end else if (S_AXIS_tvalid && S_AXIS_tuser) begin
                    push_req  = 1'b1;
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                push_req = S_AXIS_tvalid;
                if (cmd_stop) stop_pending_nxt = 1'b1;
                if (fval_fall) begin
                    if (frames_done != 16'hFFFF) frames_nxt = frames_done + 16'd1;
                    if (stop_pending || cmd_stop ||
                        (cfg_q != 16'd0 && frames_nxt == cfg_q)) begin
                        state_nxt = S_DRAIN;
                    end else begin
                        state_nxt = S_ARMED;
                    end
                end
            end
            S_DRAIN: begin
                if (count == CW'(0) && !M_AXIS_tvalid) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Sequencer registers
    always_ff @(posedge M_AXIS_aclk or negedge M_AXIS_aresetn) begin
        if (!M_AXIS_aresetn) begin
            state        <= S_IDLE;
            fval_q       <= 1'b0;
            cfg_q        <= 16'd0;
            stop_pending <= 1'b0;
            frames_done  <= 16'd0;
            overflow     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            fval_q       <= fval;
            stop_pending <= stop_pending_nxt;
            frames_done  <= frames_nxt;
            busy         <= (state_nxt != S_IDLE);
            if (start_c) begin
                cfg_q    <= frame_count_cfg;
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // FIFO control; a full FIFO still accepts a push when the head pops
    assign wdata     = {S_AXIS_tuser, S_AXIS_tlast, S_AXIS_tdata};
    assign full      = (count == CW'(FIFO_DEPTH));
    assign pop       = M_AXIS_tvalid & M_AXIS_tready;
    assign push      = push_req & (~full | pop);
    assign drop      = push_req & full & ~pop;
    assign count_nxt = count + CW'(push) - CW'(pop);
    assign rd_nxt    = rd_ptr + AW'(pop);
    // Bypass the memory when the pushed beat becomes the new head
    assign head_nxt  = (push && (count - CW'(pop)) == CW'(0)) ? wdata : mem[rd_nxt];

    always_ff @(posedge M_AXIS_aclk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // Pointers and registered head beat
    always_ff @(posedge M_AXIS_aclk or negedge M_AXIS_aresetn) begin
        if (!M_AXIS_aresetn) begin
            wr_ptr        <= AW'(0);
            rd_ptr        <= AW'(0);
            count         <= CW'(0);
            M_AXIS_tvalid <= 1'b0;
            M_AXIS_tdata  <= DW'(0);
            M_AXIS_tlast  <= 1'b0;
            M_AXIS_tuser  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr        <= rd_nxt;
            count         <= count_nxt;
            M_AXIS_tvalid <= (count_nxt != CW'(0));
            if (count_nxt != CW'(0)) begin
                {M_AXIS_tuser, M_AXIS_tlast, M_AXIS_tdata} <= head_nxt;
            end
        end
    end

`ifdef CL_LINE_CHECK_EN
    logic [15:0] line_cnt;
    logic [15:0] line_ref;
    logic [15:0] cnt_cur;
    logic        first_line;

    // tuser beat is the first beat of a new line
    assign cnt_cur = (S_AXIS_tuser ? 16'd0 : line_cnt) + 16'd1;

    // First line after tuser sets the reference; later lines must match it
    always_ff @(posedge M_AXIS_aclk or negedge M_AXIS_aresetn) begin
        if (!M_AXIS_aresetn) begin
            line_cnt     <= 16'd0;
            line_ref     <= 16'd0;
            first_line   <= 1'b0;
            line_len_err <= 1'b0;
        end else if (start_c) begin
            line_cnt     <= 16'd0;
            first_line   <= 1'b0;
            line_len_err <= 1'b0;
        end else if (push) begin
            if (S_AXIS_tlast) begin
                line_cnt <= 16'd0;
                if (S_AXIS_tuser || first_line) begin
                    line_ref   <= cnt_cur;
                    first_line <= 1'b0;
                end else if (cnt_cur != line_ref) begin
                    line_len_err <= 1'b1;
                end
            end else begin
                line_cnt <= cnt_cur;
                if (S_AXIS_tuser) first_line <= 1'b1;
            end
        end
    end
`else
    assign line_len_err = 1'b0;
`endif

endmodule

// File: tb/tb_cl_capture_ctrl.sv
// Directed testbench for cl_capture_ctrl: frame counting, mid-frame arming,
// stop at frame boundary, FIFO overflow, start/stop collision, async reset
// and (when CL_LINE_CHECK_EN is defined) line-length checking.
module tb_cl_capture_ctrl;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_tvalid, s_tlast, s_tuser, s_tready;
    logic [DW-1:0] s_tdata;
    logic          fval;
    logic          m_tready, m_tvalid, m_tlast, m_tuser;
    logic [DW-1:0] m_tdata;
    logic          cmd_start, cmd_stop;
    logic [15:0]   frame_count_cfg;
    logic          busy;
    logic [15:0]   frames_done;
    logic          overflow, line_len_err;

    int errors = 0;
    int checks = 0;
    logic [17:0] exp_q[$];
    logic [17:0] got_q[$];

    always #5 clk = ~clk;

    cl_capture_ctrl #(
        .C_AXIS_TDATA_WIDTH (DW),
        .FIFO_DEPTH         (DEPTH)
    ) dut (
        .M_AXIS_aclk     (clk),
        .M_AXIS_aresetn  (rst_n),
        .S_AXIS_tvalid   (s_tvalid),
        .S_AXIS_tdata    (s_tdata),
        .S_AXIS_tlast    (s_tlast),
        .S_AXIS_tuser    (s_tuser),
        .S_AXIS_tready   (s_tready),
        .fval            (fval),
        .M_AXIS_tready   (m_tready),
        .M_AXIS_tvalid   (m_tvalid),
        .M_AXIS_tdata    (m_tdata),
        .M_AXIS_tlast    (m_tlast),
        .M_AXIS_tuser    (m_tuser),
        .cmd_start       (cmd_start),
        .cmd_stop        (cmd_stop),
        .frame_count_cfg (frame_count_cfg),
        .busy            (busy),
        .frames_done     (frames_done),
        .overflow        (overflow),
        .line_len_err    (line_len_err)
    );

    // Record every beat the DMA side accepts
    always @(negedge clk) begin
        if (rst_n && m_tvalid && m_tready) got_q.push_back({m_tuser, m_tlast, m_tdata});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pix(input int id, input int idx);
        return {8'(id), 8'(idx)};
    endfunction

    // Advance one clock; pulses and beat strobes last a single cycle
    task automatic step();
        @(posedge clk);
        #1;
        s_tvalid  = 1'b0;
        s_tlast   = 1'b0;
        s_tuser   = 1'b0;
        cmd_start = 1'b0;
        cmd_stop  = 1'b0;
    endtask

    task automatic beat(input logic [15:0] d, input logic l, input logic u);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        s_tuser  = u;
        fval     = 1'b1;
        step();
    endtask

    task automatic pulse_start(input logic [15:0] cfg);
        frame_count_cfg = cfg;
        cmd_start       = 1'b1;
        step();
    endtask

    // Frame of lines x width beats; first n_exp beats expected on M_AXIS
    task automatic send_frame(input int id, input int lines, input int width,
                              input int n_exp, input int start_at, input int stop_at);
        for (int r = 0; r < lines; r++) begin
            for (int c = 0; c < width; c++) begin
                int idx;
                idx = r * width + c;
                if (idx == start_at) cmd_start = 1'b1;
                if (idx == stop_at)  cmd_stop  = 1'b1;
                if (idx < n_exp)
                    exp_q.push_back({(idx == 0), (c == width - 1), pix(id, idx)});
                beat(pix(id, idx), (c == width - 1), (idx == 0));
            end
        end
        fval = 1'b0;
        step();
        step();
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 400) begin
            step();
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic check_stream(input string tag);
        int n;
        chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk(tag, 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int lens [3];
        int idx;
        lens = '{8, 8, 7};

        rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tuser = 1'b0;
        fval = 1'b0; m_tready = 1'b1; cmd_start = 1'b0; cmd_stop = 1'b0;
        frame_count_cfg = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",     32'(busy),        32'd0);
        chk("rst_tvalid",   32'(m_tvalid),    32'd0);
        chk("rst_tdata",    32'(m_tdata),     32'd0);
        chk("rst_frames",   32'(frames_done), 32'd0);
        chk("rst_overflow", 32'(overflow),    32'd0);
        chk("rst_linerr",   32'(line_len_err), 32'd0);
        chk("s_tready",     32'(s_tready),    32'd1);
        rst_n = 1'b1;
        step();

        // Count of 2: frames 1,2 delivered, frame 3 ignored; cfg change after start is ignored
        pulse_start(16'd2);
        chk("t1_busy", 32'(busy), 32'd1);
        frame_count_cfg = 16'd7;
        send_frame(1, 4, 4, 16, -1, -1);
        send_frame(2, 4, 4, 16, -1, -1);
        send_frame(3, 4, 4, 0, -1, -1);
        wait_idle("t1_idle");
        chk("t1_frames", 32'(frames_done), 32'd2);
        check_stream("t1_beat");

        // Start mid-frame: partial frame 4 dropped, frame 5 captured
        frame_count_cfg = 16'd1;
        send_frame(4, 4, 4, 0, 5, -1);
        chk("t2_busy", 32'(busy), 32'd1);
        send_frame(5, 4, 4, 16, -1, -1);
        wait_idle("t2_idle");
        chk("t2_frames", 32'(frames_done), 32'd1);
        check_stream("t2_beat");

        // Continuous with stop in frame 8: frame 8 completes, then idle
        pulse_start(16'd0);
        send_frame(6, 4, 4, 16, -1, -1);
        send_frame(7, 4, 4, 16, -1, -1);
        send_frame(8, 4, 4, 16, -1, 5);
        wait_idle("t3_idle");
        chk("t3_frames", 32'(frames_done), 32'd3);
        send_frame(9, 4, 4, 0, -1, -1);
        check_stream("t3_beat");

        // Backpressure for 20 beats: 16 buffered, 4 dropped
        m_tready = 1'b0;
        pulse_start(16'd1);
        send_frame(10, 5, 4, 16, -1, -1);
        chk("t4_overflow", 32'(overflow),    32'd1);
        chk("t4_tvalid",   32'(m_tvalid),    32'd1);
        chk("t4_head",     32'(m_tdata),     32'h0A00);
        chk("t4_tuser",    32'(m_tuser),     32'd1);
        chk("t4_busy",     32'(busy),        32'd1);
        chk("t4_frames",   32'(frames_done), 32'd1);
        repeat (3) step();
        chk("t4_hold",     32'(m_tdata),     32'h0A00);
        m_tready = 1'b1;
        wait_idle("t4_idle");
        chk("t4_sticky",   32'(overflow),    32'd1);
        check_stream("t4_beat");

        // Start and stop together from idle: start ignored, flags untouched
        frame_count_cfg = 16'd0;
        cmd_start = 1'b1;
        cmd_stop  = 1'b1;
        step();
        chk("t5_busy",     32'(busy),        32'd0);
        step();
        chk("t5_busy2",    32'(busy),        32'd0);
        chk("t5_overflow", 32'(overflow),    32'd1);
        chk("t5_frames",   32'(frames_done), 32'd1);
        pulse_start(16'd0);
        chk("t5_start",    32'(busy),        32'd1);
        chk("t5_ovf_clr",  32'(overflow),    32'd0);
        chk("t5_frm_clr",  32'(frames_done), 32'd0);
        cmd_stop = 1'b1;
        step();
        wait_idle("t5_idle");

        // Line lengths 8,8,7 within one frame
        pulse_start(16'd1);
        idx = 0;
        for (int l = 0; l < 3; l++) begin
            for (int c = 0; c < lens[l]; c++) begin
                exp_q.push_back({(idx == 0), (c == lens[l] - 1), pix(11, idx)});
                beat(pix(11, idx), (c == lens[l] - 1), (idx == 0));
                idx++;
            end
            if (l == 1) chk("t6_err_ok", 32'(line_len_err), 32'd0);
        end
`ifdef CL_LINE_CHECK_EN
        chk("t6_err_set", 32'(line_len_err), 32'd1);
`else
        chk("t6_err_off", 32'(line_len_err), 32'd0);
`endif
        fval = 1'b0;
        step();
        wait_idle("t6_idle");
        check_stream("t6_beat");
        pulse_start(16'd0);
        chk("t6_err_clr", 32'(line_len_err), 32'd0);
        cmd_stop = 1'b1;
        step();
        wait_idle("t6_idle2");

        // Async reset mid-frame discards buffered beats immediately
        m_tready = 1'b0;
        pulse_start(16'd0);
        for (int i = 0; i < 6; i++) beat(pix(12, i), 1'b0, (i == 0));
        chk("t7_pre", 32'(m_tvalid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_tvalid", 32'(m_tvalid),    32'd0);
        chk("t7_busy",   32'(busy),        32'd0);
        chk("t7_frames", 32'(frames_done), 32'd0);
        fval = 1'b0;
        step();
        rst_n = 1'b1;
        m_tready = 1'b1;
        repeat (3) step();
        check_stream("t7_beat");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cl_capture_ctrl.md
Name: cl_capture_ctrl

Overview:
- Capture sequencer between the Camera Link receive AXIS stream and the downstream video DMA/VDMA.
- Arms on software command and aligns to the next start-of-frame (tuser); forwards whole frames only.
- Stops after a programmed frame count, or at the next frame boundary on stop command.
- Buffers the non-stallable receiver output in a small FIFO and reports overflow and capture status.

Parameters:
- C_AXIS_TDATA_WIDTH, 16, pixel payload width on both AXIS sides.
- FIFO_DEPTH, 16, beat buffer depth; power of two, minimum 2.

Ports:
- M_AXIS_aclk  in  1  clock for all logic.
- M_AXIS_aresetn  in  1  asynchronous, active-low reset.
- S_AXIS_tvalid  in  1  receiver beat valid.
- S_AXIS_tdata  in  C_AXIS_TDATA_WIDTH  receiver pixel.
- S_AXIS_tlast  in  1  end of line.
- S_AXIS_tuser  in  1  start of frame.
- S_AXIS_tready  out  1  tied to 1; the receiver cannot stall.
- fval  in  1  Camera Link frame-valid, aligned to the S_AXIS beats.
- M_AXIS_tready  in  1  downstream ready.
- M_AXIS_tvalid  out  1  output beat valid.
- M_AXIS_tdata  out  C_AXIS_TDATA_WIDTH  output pixel.
- M_AXIS_tlast  out  1  end of line.
- M_AXIS_tuser  out  1  start of frame.
- cmd_start  in  1  one-cycle pulse; arm capture.
- cmd_stop  in  1  one-cycle pulse; stop at frame boundary.
- frame_count_cfg  in  16  frames to capture; 0 = continuous.
- busy  out  1  state != IDLE.
- frames_done  out  16  completed frames since last start.
- overflow  out  1  sticky: a beat was dropped because the FIFO was full.
- line_len_err  out  1  sticky line-length mismatch; constant 0 without CL_LINE_CHECK_EN.

Behaviour:
- Clock and reset: clock M_AXIS_aclk; reset M_AXIS_aresetn, asynchronous, active-low.
- Reset values: state=IDLE, FIFO empty, M_AXIS_tvalid=0, tdata/tlast/tuser=0, frames_done=0, overflow=0, line_len_err=0, stop_pending=0.
- States: IDLE, ARMED, CAPTURE, DRAIN.
  - IDLE: cmd_start -> ARMED; clears frames_done, overflow, line_len_err and stop_pending. cmd_start is ignored in every other state.
  - ARMED: beats without tuser are discarded. A beat with tuser is pushed -> CAPTURE. cmd_stop -> DRAIN.
  - CAPTURE: every S_AXIS_tvalid beat is pushed. cmd_stop sets stop_pending. On fval falling edge (registered fval=1, current fval=0):
    - frames_done increments; saturates at 0xFFFF.
    - If stop_pending, or frame_count_cfg!=0 and the new frames_done==frame_count_cfg -> DRAIN.
    - Otherwise -> ARMED.
  - DRAIN: no pushes; -> IDLE when the FIFO is empty and no output beat is pending.
- Simultaneous cmd_start and cmd_stop: stop wins; start is ignored.
- frame_count_cfg is sampled only at cmd_start. Changing it mid-capture has no effect.
- FIFO holds {tuser, tlast, tdata}.
  - Push: the S_AXIS beat is pushed into the FIFO in the same cycle it is accepted.
  - Output: the M_AXIS output is registered, so a beat accepted at cycle N is first visible on M_AXIS at cycle N+1 when the FIFO was empty.
  - Pop on M_AXIS_tvalid & M_AXIS_tready. tdata/tlast/tuser hold stable while tvalid=1 and tready=0.
  - Full with simultaneous pop: the push is accepted.
  - Full without pop: the beat is dropped and overflow is set (sticky until next cmd_start). A dropped beat does not change state; the frame still completes on fval.
- A reset in any state returns to the reset values immediately; a partial frame in the FIFO is lost.

Optional Feature:
- Macro CL_LINE_CHECK_EN.
- Defined:
  - A 16-bit counter counts pushed beats per line.
  - The first line after each tuser latches the reference length.
  - A subsequent tlast with a count != reference sets line_len_err (sticky until cmd_start).
  - The counter resets on tlast and on tuser.
- Not defined: no counter logic; line_len_err tied to 0.

Test Plan:
- cmd_start, cfg=2, three 4x4-pixel frames with tready=1 -> exactly 2 frames (32 beats) on M_AXIS, first beat tuser=1; frames_done=2; busy drops after last beat.
- cmd_start in mid-frame -> partial frame discarded; output starts at the next tuser beat.
- cfg=0 and cmd_stop mid-frame 3 -> frame 3 completes fully, frames_done=3, then IDLE.
- FIFO_DEPTH=16, tready=0 for 20 beats -> 16 beats buffered, overflow=1. After tready=1 the 16 beats are delivered in order, unchanged.
- cmd_start and cmd_stop in the same cycle from IDLE -> stays IDLE, busy=0.
- CL_LINE_CHECK_EN, line lengths 8,8,7 -> line_len_err=1 at the tlast of the 7-beat line; cmd_start clears it.
